and3_stim_checker: RTL and testbench

- Stimulus driver and response checker for a 3-input AND cell under test, e.g. an AND3X4 instance in a power/characterisation harness.
- Drives the cell's three inputs through a Gray-code walk, so exactly one input toggles per step and each input arc is exercised.
- Synchronises the cell's Q output, compares it against the expected AND3 value and accumulates a pass/fail result.

---
 rtl/and3_stim_checker.sv | 159 +++++++++++++++
 tb/tb_and3_stim_checker.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/and3_stim_checker.sv
// rtl/and3_stim_checker.sv - Gray-walk stimulus driver and response checker for an AND3 cell
module and3_stim_checker #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned PASSES        = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       ABORT,
    input  logic       Q_OBS,
    output logic       IN1_DRV,
    output logic       IN2_DRV,
    output logic       IN3_DRV,
    output logic       BUSY,
    output logic       DONE,
    output logic       FAIL,
    output logic [7:0] ERR_CNT,
    output logic [2:0] FIRST_ERR_VEC
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Settle counter counts down to zero, so it is loaded one short of the hold time.
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] LAST_PASS   = 8'(PASSES - 1);

    state_t     state_q;
    logic [2:0] drv_q;
    logic [2:0] step_q;
    logic [7:0] pass_q;
    logic [7:0] settle_q;
    logic       busy_q;
    logic       done_q;
    logic       fail_q;
    logic [7:0] err_q;
    logic [2:0] first_q;
    logic       q_s1_q;
    logic       q_s2_q;

    logic       mismatch_d;
    logic [7:0] err_d;

    function automatic logic [2:0] gray3(input logic [2:0] s);
        return s ^ (s >> 1);
    endfunction

    // Two-flop synchroniser for the cell output, which is asynchronous to CLK.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            q_s1_q <= 1'b0;
            q_s2_q <= 1'b0;
        end else begin
            q_s1_q <= Q_OBS;
            q_s2_q <= q_s1_q;
        end
    end

    // Expected response is the AND of the held drives; error count saturates at 255.
    always_comb begin
        mismatch_d = (q_s2_q != (&drv_q));
        err_d      = err_q;
        if (err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
        end
    end

    // Sequencer: walks the Gray vectors, holds each for the settle time, then checks.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            drv_q    <= 3'b000;
            step_q   <= 3'd0;
            pass_q   <= 8'd0;
            settle_q <= 8'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fail_q   <= 1'b0;
            err_q    <= 8'd0;
            first_q  <= 3'b000;
        end else if (ABORT && busy_q) begin
            // Abort keeps the error record so a partial run can still be inspected.
            state_q <= ST_IDLE;
            drv_q   <= 3'b000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (START) begin
                        state_q <= ST_APPLY;
                        drv_q   <= gray3(3'd0);
                        step_q  <= 3'd0;
                        pass_q  <= 8'd0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        fail_q  <= 1'b0;
                        err_q   <= 8'd0;
                        first_q <= 3'b000;
                    end
                end
                ST_APPLY: begin
                    settle_q <= SETTLE_LOAD;
                    state_q  <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_q == 8'd0) begin
                        state_q <= ST_CHECK;
                    end else begin
                        settle_q <= settle_q - 8'd1;
                    end
                end
                ST_CHECK: begin
                    if (mismatch_d) begin
                        fail_q <= 1'b1;
                        err_q  <= err_d;
                        if (!fail_q) begin
                            first_q <= drv_q;
                        end
                    end
                    if (step_q != 3'd7) begin
                        step_q  <= step_q + 3'd1;
                        drv_q   <= gray3(step_q + 3'd1);
                        state_q <= ST_APPLY;
                    end else if (pass_q != LAST_PASS) begin
                        // Wrapping 100 -> 000 toggles only IN1, so the arc stays single-bit.
                        pass_q  <= pass_q + 8'd1;
                        step_q  <= 3'd0;
                        drv_q   <= gray3(3'd0);
                        state_q <= ST_APPLY;
                    end else begin
                        drv_q   <= 3'b000;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign IN1_DRV       = drv_q[2];
    assign IN2_DRV       = drv_q[1];
    assign IN3_DRV       = drv_q[0];
    assign BUSY          = busy_q;
    assign DONE          = done_q;
    assign FAIL          = fail_q;
    assign ERR_CNT       = err_q;
    assign FIRST_ERR_VEC = first_q;

endmodule

// File: tb/tb_and3_stim_checker.sv
// tb/tb_and3_stim_checker.sv - Bench for and3_stim_checker
module tb_and3_stim_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic abort;
    logic start_a, start_b, start_c, start_d;
    logic [7:0] mask_a, mask_b, mask_c, mask_d;

    wire [2:0] drv_a, drv_b, drv_c, drv_d;
    wire       busy_a, busy_b, busy_c, busy_d;
    wire       done_a, done_b, done_c, done_d;
    wire       fail_a, fail_b, fail_c, fail_d;
    wire [7:0] err_a, err_b, err_c, err_d;
    wire [2:0] first_a, first_b, first_c, first_d;
    wire       q_a, q_b, q_c, q_d;

    // Each cell under test is a truth table indexed by {IN1,IN2,IN3}.
    assign q_a = mask_a[drv_a];
    assign q_b = mask_b[drv_b];
    assign q_c = mask_c[drv_c];
    assign q_d = mask_d[drv_d];

    and3_stim_checker u_a (
        .CLK(clk), .RST(rst), .START(start_a), .ABORT(abort), .Q_OBS(q_a),
        .IN1_DRV(drv_a[2]), .IN2_DRV(drv_a[1]), .IN3_DRV(drv_a[0]),
        .BUSY(busy_a), .DONE(done_a), .FAIL(fail_a), .ERR_CNT(err_a), .FIRST_ERR_VEC(first_a));

    and3_stim_checker #(.SETTLE_CYCLES(4), .PASSES(3)) u_b (
        .CLK(clk), .RST(rst), .START(start_b), .ABORT(abort), .Q_OBS(q_b),
        .IN1_DRV(drv_b[2]), .IN2_DRV(drv_b[1]), .IN3_DRV(drv_b[0]),
        .BUSY(busy_b), .DONE(done_b), .FAIL(fail_b), .ERR_CNT(err_b), .FIRST_ERR_VEC(first_b));

    and3_stim_checker #(.SETTLE_CYCLES(4), .PASSES(40)) u_c (
        .CLK(clk), .RST(rst), .START(start_c), .ABORT(abort), .Q_OBS(q_c),
        .IN1_DRV(drv_c[2]), .IN2_DRV(drv_c[1]), .IN3_DRV(drv_c[0]),
        .BUSY(busy_c), .DONE(done_c), .FAIL(fail_c), .ERR_CNT(err_c), .FIRST_ERR_VEC(first_c));

    and3_stim_checker #(.SETTLE_CYCLES(2), .PASSES(1)) u_d (
        .CLK(clk), .RST(rst), .START(start_d), .ABORT(abort), .Q_OBS(q_d),
        .IN1_DRV(drv_d[2]), .IN2_DRV(drv_d[1]), .IN3_DRV(drv_d[0]),
        .BUSY(busy_d), .DONE(done_d), .FAIL(fail_d), .ERR_CNT(err_d), .FIRST_ERR_VEC(first_d));

    int n_chk  = 0;
    int n_fail = 0;

    logic [2:0] gray_tab [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

    typedef struct {
        logic [7:0] mask;
        int         err;
        int         fl;
        int         first;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: walk every vector of every pass, count disagreements with AND3.
    function automatic void model(input logic [7:0] m, input int passes,
                                  output int err, output int fl, output int first);
        err   = 0;
        fl    = 0;
        first = 0;
        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i < 8; i++) begin
                if (m[gray_tab[i]] != (gray_tab[i] == 3'b111)) begin
                    if (fl == 0) first = int'(gray_tab[i]);
                    fl = 1;
                    if (err < 255) err++;
                end
            end
        end
    endfunction

    // Full default-parameter run on instance A with a cycle-by-cycle drive trace.
    task automatic run_a(input logic [7:0] m, input int e_err, input int e_fail, input int e_first);
        mask_a  = m;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int k = 0; k < 48; k++) begin
            chk("walk_drive", int'(drv_a), int'(gray_tab[k / 6]));
            chk("walk_busy_done", int'({busy_a, done_a}), 2);
            tick();
        end
        chk("end_done", int'(done_a), 1);
        chk("end_busy", int'(busy_a), 0);
        chk("end_drive", int'(drv_a), 0);
        chk("end_err_cnt", int'(err_a), e_err);
        chk("end_fail", int'(fail_a), e_fail);
        chk("end_first_vec", int'(first_a), e_first);
    endtask

    function automatic logic done_of(input int w);
        case (w)
            1: return done_b;
            2: return done_c;
            default: return done_d;
        endcase
    endfunction

    // Starts instance B/C/D and counts edges until DONE, bounded.
    task automatic run_inst(input int w, output int edges);
        case (w)
            1: start_b = 1'b1;
            2: start_c = 1'b1;
            default: start_d = 1'b1;
        endcase
        tick();
        start_b = 1'b0;
        start_c = 1'b0;
        start_d = 1'b0;
        edges = 0;
        while (!done_of(w) && edges < 5000) begin
            tick();
            edges++;
        end
    endtask

    initial begin
        int edges;
        int e_err, e_fl, e_first;
        logic [7:0] m;

        tbl[0] = '{8'h80, 0, 0, 0};
        tbl[1] = '{8'h00, 1, 1, 7};
        tbl[2] = '{8'hFF, 7, 1, 0};
        tbl[3] = '{8'h7F, 8, 1, 0};
        tbl[4] = '{8'h82, 1, 1, 1};
        tbl[5] = '{8'hC0, 1, 1, 6};

        rst = 1'b1; abort = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; start_d = 1'b0;
        mask_a = 8'h80; mask_b = 8'hFF; mask_c = 8'hFF; mask_d = 8'h80;
        tick();
        tick();
        chk("rst_drive", int'(drv_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_fail", int'(fail_a), 0);
        chk("rst_err_cnt", int'(err_a), 0);
        chk("rst_first_vec", int'(first_a), 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_a(tbl[i].mask, tbl[i].err, tbl[i].fl, tbl[i].first);
        end

        // ABORT while in DONE leaves the result alone.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_in_done_done", int'(done_a), 1);
        chk("abort_in_done_err", int'(err_a), 1);

        for (int r = 0; r < 6; r++) begin
            m = 8'($urandom);
            model(m, 1, e_err, e_fl, e_first);
            run_a(m, e_err, e_fl, e_first);
        end

        // START mid-run ignored; START+ABORT together aborts and keeps errors.
        mask_a  = 8'hFF;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int k = 1; k < 10; k++) tick();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("start_while_busy_busy", int'(busy_a), 1);
        chk("start_while_busy_drive", int'(drv_a), int'(gray_tab[1]));
        for (int k = 11; k < 20; k++) tick();
        abort   = 1'b1;
        start_a = 1'b1;
        tick();
        abort   = 1'b0;
        start_a = 1'b0;
        chk("abort_busy", int'(busy_a), 0);
        chk("abort_done", int'(done_a), 0);
        chk("abort_drive", int'(drv_a), 0);
        chk("abort_err_kept", int'(err_a), 3);
        chk("abort_fail_kept", int'(fail_a), 1);
        tick();
        chk("abort_stays_idle", int'(busy_a), 0);
        run_a(tbl[0].mask, 0, 0, 0);

        // Asynchronous reset in the middle of a settle window.
        mask_a  = 8'hFF;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int k = 1; k < 9; k++) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_err", int'(err_a), 0);
        chk("async_rst_fail", int'(fail_a), 0);
        chk("async_rst_busy", int'(busy_a), 0);
        chk("async_rst_drive", int'(drv_a), 0);
        chk("async_rst_first", int'(first_a), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_idle", int'(busy_a), 0);
        run_a(tbl[0].mask, 0, 0, 0);

        // Multi-pass, saturation and minimum settle time instances.
        run_inst(1, edges);
        chk("p3_done_edge", edges, 144);
        chk("p3_err_cnt", int'(err_b), 21);
        chk("p3_first_vec", int'(first_b), 0);
        chk("p3_fail", int'(fail_b), 1);

        run_inst(2, edges);
        chk("p40_done_edge", edges, 1920);
        chk("p40_err_sat", int'(err_c), 255);
        chk("p40_fail", int'(fail_c), 1);

        run_inst(3, edges);
        chk("s2_done_edge", edges, 32);
        chk("s2_ideal_err", int'(err_d), 0);
        mask_d = 8'h00;
        run_inst(3, edges);
        chk("s2_stuck0_err", int'(err_d), 1);
        chk("s2_stuck0_first", int'(first_d), 7);
        for (int r = 0; r < 3; r++) begin
            mask_d = 8'($urandom);
            model(mask_d, 1, e_err, e_fl, e_first);
            run_inst(3, edges);
            chk("s2_rand_err", int'(err_d), e_err);
            chk("s2_rand_first", int'(first_d), e_first);
            chk("s2_rand_fail", int'(fail_d), e_fl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
